leaf_fill_scheduler: RTL and testbench
======================================

# leaf_fill_scheduler

Round-robin read-request scheduler that keeps the merger tree's leaf input buffers filled from memory. Each leaf owns a contiguous region of 512-bit lines. The block issues one line-read per grant on an AXI-style AR channel, tagged with the leaf index. It routes returning R beats into the matching leaf buffer and tracks per-leaf credits so a buffer can never overflow. It sits between the memory read port and the per-leaf 512-bit buffers that feed the 32-bit leaf FIFOs of the merger tree.

## Interface
- LEAF_CNT, 64, number of leaves; power of two, ≥2
- ADDR_WIDTH, 32, byte-address width
- LINE_BYTES, 64, bytes per line; fixed 512-bit data
- BUF_DEPTH, 8, lines of capacity in each leaf buffer
- LEN_WIDTH, 32, width of per-leaf line count

- i_clk  in  1  clock; all logic is rising-edge
- i_rst_n  in  1  asynchronous, active-low reset
- i_cfg_we  in  1  write one leaf's configuration
- i_cfg_leaf  in  log2(LEAF_CNT)  leaf index for the configuration write
- i_cfg_base  in  ADDR_WIDTH  leaf region base byte address, LINE_BYTES-aligned
- i_cfg_lines  in  LEN_WIDTH  number of lines to fetch for the leaf
- i_start  in  1  one-cycle pulse that begins a run
- o_busy  out  1  high in RUN or DRAIN
- o_done  out  1  held high in DONE until the next i_start
- o_arvalid  out  1  read request valid
- i_arready  in  1  read request accepted
- o_araddr  out  ADDR_WIDTH  request byte address
- o_arid  out  log2(LEAF_CNT)  requesting leaf
- i_rvalid  in  1  read data valid
- i_rid  in  log2(LEAF_CNT)  leaf tag of the data
- i_rdata  in  512  line data
- o_rready  out  1  tied high whenever not in reset
- o_buf_enq  out  LEAF_CNT  one-hot enqueue to the leaf buffer
- o_buf_data  out  512  data for the leaf buffer
- i_buf_deq  in  LEAF_CNT  per-leaf pulse: one line left the buffer

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- Configuration writes are accepted only in IDLE or DONE. In RUN and DRAIN they are ignored.
- Each configuration write loads the leaf's base, its remaining line count and its issued-line index (set to 0).
- IDLE→RUN on i_start. At the same transition all credits are set to BUF_DEPTH and the round-robin pointer is set to 0.
- i_start is ignored in RUN and DRAIN.
- DONE→RUN on i_start re-runs the leaves with their current configuration, reloaded as on a fresh start.
- Eligible leaf: remaining > 0 and credit > 0.
- Arbitration picks the first eligible leaf at or after the pointer, modulo LEAF_CNT. After a grant the pointer becomes the granted leaf + 1. Burst size is one line.
- On a grant:
  - o_araddr = base + issued×LINE_BYTES, truncated to ADDR_WIDTH.
  - o_arid = the granted leaf.
  - The leaf's issued count increments, its remaining count decrements and its credit decrements.
  - The outstanding counter increments.
- Credits:
  - An i_buf_deq pulse increments that leaf's credit; credit is capped at BUF_DEPTH.
  - A simultaneous grant and deq on the same leaf leaves the credit unchanged.
- Response path: an i_rvalid beat decrements the outstanding counter and sets o_buf_enq[i_rid] in the next cycle, with o_buf_data = i_rdata.
- An R beat and an AR handshake in the same cycle leave the outstanding counter unchanged.
- RUN→DRAIN when every leaf's remaining count is 0 and no request is pending.
- DRAIN→DONE when the outstanding count is 0.
- A run in which every leaf has 0 lines goes RUN→DRAIN→DONE in 2 cycles.

## Timing
- Reset values:
  - State IDLE; o_arvalid, o_busy, o_done, o_rready and o_buf_enq are 0.
  - o_araddr, o_arid and o_buf_data are 0; credits are 0; pointer is 0.
  - Configuration registers are 0.
- Reset asserted mid-run aborts immediately. In-flight R beats arriving after reset are dropped.
- AR channel:
  - The request is registered. o_arvalid rises 1 cycle after a grant.
  - o_araddr and o_arid stay stable while o_arvalid is high and i_arready is low.
  - No new grant is made while a request is pending and unaccepted.
  - When o_arvalid and i_arready are both high, a new grant may load in the same edge, giving one request per cycle sustained.
- First o_arvalid is 2 cycles after i_start: the cycle after start arbitrates, the next presents the request.
- Response latency: i_rvalid at edge n produces o_buf_enq at edge n+1. It is a single pulse and does not depend on AR activity.
- An R beat with i_rvalid outside RUN/DRAIN is still forwarded. The outstanding count saturates at 0.

## Test plan
- Single leaf: leaf 5, base 0x1000, 3 lines, i_arready always high → AR addresses 0x1000, 0x1040, 0x1080 with id 5 in consecutive cycles. Respond to each → o_done rises 1 cycle after the last o_buf_enq.
- Round-robin fairness: all 64 leaves with 2 lines each, no backpressure → ids in the order 0..63, 0..63; 128 requests; o_done after the final response drains.
- Credit stall: BUF_DEPTH=8, leaf 0 with 20 lines, no i_buf_deq → exactly 8 requests, then o_arvalid low. One deq pulse → exactly one more request, at address base+8×64.
- AR backpressure: hold i_arready low for 10 cycles with a request pending → o_araddr and o_arid stable and no counter changes. Release → the next request follows in the next cycle.
- Simultaneous events: an R beat and an AR handshake in the same cycle, plus a deq and a grant on the same leaf → outstanding and credit unchanged, and the final o_done timing is correct.
- Zero lines and reset: all leaves with 0 lines → o_done 2 cycles after i_start. Then start a 10-line run and pull i_rst_n low mid-run → all outputs 0 asynchronously and state IDLE.

Source files
------------

// File: rtl/leaf_fill_scheduler.sv
// Round-robin line-read scheduler that keeps the merger-tree leaf buffers topped up.
// One AR per grant, tagged with the leaf index; R beats are routed back by tag.

module leaf_fill_slot #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 32,
    parameter int BUF_DEPTH  = 8,
    parameter int CW         = $clog2(BUF_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_we,
    input  logic [ADDR_WIDTH-1:0] cfg_base,
    input  logic [LEN_WIDTH-1:0]  cfg_lines,
    input  logic                  load,
    input  logic                  grant,
    input  logic                  deq,
    output logic                  pending,
    output logic                  eligible,
    output logic [ADDR_WIDTH-1:0] base,
    output logic [LEN_WIDTH-1:0]  issued
);
    logic [ADDR_WIDTH-1:0] base_q;
    logic [LEN_WIDTH-1:0]  lines_q, rem_q, issued_q;
    logic [CW-1:0]         credit_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q   <= '0;
            lines_q  <= '0;
            rem_q    <= '0;
            issued_q <= '0;
            credit_q <= '0;
        end else begin
            if (cfg_we) begin
                base_q   <= cfg_base;
                lines_q  <= cfg_lines;
                rem_q    <= cfg_lines;
                issued_q <= '0;
            end
            if (load) begin
                rem_q    <= lines_q;
                issued_q <= '0;
                credit_q <= CW'(BUF_DEPTH);
            end else begin
                if (grant) begin
                    issued_q <= issued_q + LEN_WIDTH'(1);
                    rem_q    <= rem_q - LEN_WIDTH'(1);
                end
                // a deq landing with a grant cancels out; otherwise deq refills up to the cap
                if (grant && !deq)
                    credit_q <= credit_q - CW'(1);
                else if (!grant && deq && credit_q != CW'(BUF_DEPTH))
                    credit_q <= credit_q + CW'(1);
            end
        end
    end

    assign pending  = (rem_q != '0);
    assign eligible = pending && (credit_q != '0);
    assign base     = base_q;
    assign issued   = issued_q;
endmodule

module leaf_fill_scheduler #(
    parameter int LEAF_CNT   = 64,
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_BYTES = 64,
    parameter int BUF_DEPTH  = 8,
    parameter int LEN_WIDTH  = 32
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_cfg_we,
    input  logic [$clog2(LEAF_CNT)-1:0] i_cfg_leaf,
    input  logic [ADDR_WIDTH-1:0]       i_cfg_base,
    input  logic [LEN_WIDTH-1:0]        i_cfg_lines,
    input  logic                        i_start,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_arvalid,
    input  logic                        i_arready,
    output logic [ADDR_WIDTH-1:0]       o_araddr,
    output logic [$clog2(LEAF_CNT)-1:0] o_arid,
    input  logic                        i_rvalid,
    input  logic [$clog2(LEAF_CNT)-1:0] i_rid,
    input  logic [511:0]                i_rdata,
    output logic                        o_rready,
    output logic [LEAF_CNT-1:0]         o_buf_enq,
    output logic [511:0]                o_buf_data,
    input  logic [LEAF_CNT-1:0]         i_buf_deq
);
    localparam int LW = $clog2(LEAF_CNT);
    localparam int LB = $clog2(LINE_BYTES);
    localparam int OW = $clog2(LEAF_CNT * BUF_DEPTH + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic                  valid;
        logic [ADDR_WIDTH-1:0] addr;
        logic [LW-1:0]         id;
    } ar_req_t;

    state_t  state_q, state_d;
    ar_req_t ar_q;
    logic [LW-1:0] rr_ptr, gnt_idx, probe;
    logic          gnt_found, grant, cfg_ok, load, all_empty;
    logic [OW-1:0] out_q;
    logic          rready_q;
    logic [LEAF_CNT-1:0] enq_q;
    logic [511:0]        data_q;

    logic [LEAF_CNT-1:0]                 leaf_pend, leaf_elig, leaf_we, leaf_gnt;
    logic [LEAF_CNT-1:0][ADDR_WIDTH-1:0] leaf_base;
    logic [LEAF_CNT-1:0][LEN_WIDTH-1:0]  leaf_issued;

    assign cfg_ok    = (state_q == S_IDLE) || (state_q == S_DONE);
    assign load      = i_start && cfg_ok;
    assign all_empty = ~|leaf_pend;

    genvar g;
    generate
        for (g = 0; g < LEAF_CNT; g++) begin : g_leaf
            assign leaf_we[g]  = i_cfg_we && cfg_ok && (i_cfg_leaf == LW'(g));
            assign leaf_gnt[g] = grant && (gnt_idx == LW'(g));
            leaf_fill_slot #(
                .ADDR_WIDTH(ADDR_WIDTH), .LEN_WIDTH(LEN_WIDTH), .BUF_DEPTH(BUF_DEPTH)
            ) u_slot (
                .clk      (i_clk),
                .rst_n    (i_rst_n),
                .cfg_we   (leaf_we[g]),
                .cfg_base (i_cfg_base),
                .cfg_lines(i_cfg_lines),
                .load     (load),
                .grant    (leaf_gnt[g]),
                .deq      (i_buf_deq[g]),
                .pending  (leaf_pend[g]),
                .eligible (leaf_elig[g]),
                .base     (leaf_base[g]),
                .issued   (leaf_issued[g])
            );
        end
    endgenerate

    // first eligible leaf at or after the pointer; index arithmetic wraps in LW bits
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        probe     = '0;
        for (int k = 0; k < LEAF_CNT; k++) begin
            probe = rr_ptr + LW'(k);
            if (!gnt_found && leaf_elig[probe]) begin
                gnt_found = 1'b1;
                gnt_idx   = probe;
            end
        end
    end

    assign grant = (state_q == S_RUN) && gnt_found && (!ar_q.valid || i_arready);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (i_start) state_d = S_RUN;
            S_RUN:   if (all_empty && !ar_q.valid) state_d = S_DRAIN;
            S_DRAIN: if (out_q == '0) state_d = S_DONE;
            S_DONE:  if (i_start) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        o_busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        o_done = (state_q == S_DONE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ar_q     <= '0;
            rr_ptr   <= '0;
            out_q    <= '0;
            rready_q <= 1'b0;
            enq_q    <= '0;
            data_q   <= '0;
        end else begin
            rready_q <= 1'b1;
            if (grant) begin
                ar_q.valid <= 1'b1;
                ar_q.addr  <= leaf_base[gnt_idx] + (ADDR_WIDTH'(leaf_issued[gnt_idx]) << LB);
                ar_q.id    <= gnt_idx;
            end else if (i_arready) begin
                ar_q.valid <= 1'b0;
            end

            if (load)       rr_ptr <= '0;
            else if (grant) rr_ptr <= gnt_idx + LW'(1);

            // a beat returning alongside a new grant nets to zero; decrements floor at 0
            if (grant && !i_rvalid)
                out_q <= out_q + OW'(1);
            else if (!grant && i_rvalid && out_q != '0)
                out_q <= out_q - OW'(1);

            enq_q <= i_rvalid ? (LEAF_CNT'(1) << i_rid) : '0;
            if (i_rvalid) data_q <= i_rdata;
        end
    end

    assign o_arvalid  = ar_q.valid;
    assign o_araddr   = ar_q.addr;
    assign o_arid     = ar_q.id;
    assign o_rready   = rready_q;
    assign o_buf_enq  = enq_q;
    assign o_buf_data = data_q;
endmodule

// File: tb/tb_leaf_fill_scheduler.sv
// Scoreboard bench for leaf_fill_scheduler: expected AR requests and buffer enqueues
// are queued as stimulus is set up and checked as the DUT produces them.

module tb_leaf_fill_scheduler;
    logic         i_clk, i_rst_n;
    logic         i_cfg_we;
    logic [5:0]   i_cfg_leaf;
    logic [31:0]  i_cfg_base, i_cfg_lines;
    logic         i_start;
    logic         o_busy, o_done;
    logic         o_arvalid, i_arready;
    logic [31:0]  o_araddr;
    logic [5:0]   o_arid;
    logic         i_rvalid;
    logic [5:0]   i_rid;
    logic [511:0] i_rdata;
    logic         o_rready;
    logic [63:0]  o_buf_enq;
    logic [511:0] o_buf_data;
    logic [63:0]  i_buf_deq;

    leaf_fill_scheduler #(
        .LEAF_CNT(64), .ADDR_WIDTH(32), .LINE_BYTES(64), .BUF_DEPTH(8), .LEN_WIDTH(32)
    ) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_cfg_we(i_cfg_we), .i_cfg_leaf(i_cfg_leaf), .i_cfg_base(i_cfg_base),
        .i_cfg_lines(i_cfg_lines), .i_start(i_start),
        .o_busy(o_busy), .o_done(o_done),
        .o_arvalid(o_arvalid), .i_arready(i_arready), .o_araddr(o_araddr), .o_arid(o_arid),
        .i_rvalid(i_rvalid), .i_rid(i_rid), .i_rdata(i_rdata), .o_rready(o_rready),
        .o_buf_enq(o_buf_enq), .o_buf_data(o_buf_data), .i_buf_deq(i_buf_deq)
    );

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    typedef struct { logic [31:0] addr; logic [5:0] id; } ar_t;
    typedef struct { logic [63:0] oh; logic [511:0] data; } enq_t;

    ar_t        exp_ar[$];
    enq_t       exp_enq[$];
    logic [5:0] resp_q[$];
    int n_cmp = 0, n_bad = 0, ar_hs = 0, resp_seq = 0;

    // scoreboard monitor: AR handshakes and buffer enqueues, sampled mid-cycle
    initial begin : mon
        ar_t  ea;
        enq_t ee;
        forever begin
            @(negedge i_clk);
            if (i_rst_n) begin
                if (o_arvalid && i_arready) begin
                    ar_hs++;
                    resp_q.push_back(o_arid);
                    n_cmp++;
                    if (exp_ar.size() == 0) begin
                        n_bad++;
                        $display("FAIL ar_unexpected: got addr=%h id=%0d, expected no request", o_araddr, o_arid);
                    end else begin
                        ea = exp_ar.pop_front();
                        if (o_araddr !== ea.addr || o_arid !== ea.id) begin
                            n_bad++;
                            $display("FAIL ar_req: got addr=%h id=%0d, expected addr=%h id=%0d",
                                     o_araddr, o_arid, ea.addr, ea.id);
                        end
                    end
                end
                if (o_buf_enq !== '0) begin
                    n_cmp++;
                    if (exp_enq.size() == 0) begin
                        n_bad++;
                        $display("FAIL enq_unexpected: got enq=%h, expected none", o_buf_enq);
                    end else begin
                        ee = exp_enq.pop_front();
                        if (o_buf_enq !== ee.oh || o_buf_data[31:0] !== ee.data[31:0] ||
                            o_buf_data[511:480] !== ee.data[511:480]) begin
                            n_bad++;
                            $display("FAIL enq: got enq=%h data=%h, expected enq=%h data=%h",
                                     o_buf_enq, o_buf_data[31:0], ee.oh, ee.data[31:0]);
                        end
                    end
                end
            end
        end
    end

    // memory model: answers each accepted request one cycle later, in order
    initial begin : mem
        enq_t       ee;
        logic [31:0] w;
        i_rvalid = 1'b0;
        i_rid    = '0;
        i_rdata  = '0;
        forever begin
            @(posedge i_clk);
            #1;
            if (i_rst_n && resp_q.size() > 0) begin
                w        = 32'hA500_0000 + resp_seq;
                resp_seq++;
                i_rid    = resp_q.pop_front();
                i_rdata  = {16{w}};
                i_rvalid = 1'b1;
                ee.oh    = 64'd1 << i_rid;
                ee.data  = {16{w}};
                exp_enq.push_back(ee);
            end else begin
                i_rvalid = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_sb();
        exp_ar.delete();
        exp_enq.delete();
        resp_q.delete();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        i_cfg_we = 1'b0; i_cfg_leaf = '0; i_cfg_base = '0; i_cfg_lines = '0;
        i_start = 1'b0; i_arready = 1'b1; i_buf_deq = '0;
        clear_sb();
        repeat (2) tick();
        i_rst_n = 1'b1;
        tick();
    endtask

    task automatic cfg(input int leaf, input logic [31:0] base, input logic [31:0] lines);
        i_cfg_we = 1'b1; i_cfg_leaf = 6'(leaf); i_cfg_base = base; i_cfg_lines = lines;
        tick();
        i_cfg_we = 1'b0;
    endtask

    task automatic push_ar(input logic [31:0] addr, input int id);
        ar_t e;
        e.addr = addr;
        e.id   = 6'(id);
        exp_ar.push_back(e);
    endtask

    task automatic start_run();
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
    endtask

    // observes negedges until o_done; cycle indices are relative to the call
    task automatic run_until_done(input int max, output int last_enq, output int done_cyc,
                                  output int first_hs, output int last_hs);
        last_enq = -1; done_cyc = -1; first_hs = -1; last_hs = -1;
        for (int c = 0; c < max; c++) begin
            @(negedge i_clk);
            if (o_buf_enq !== '0) last_enq = c;
            if (o_arvalid && i_arready) begin
                if (first_hs < 0) first_hs = c;
                last_hs = c;
            end
            if (o_done) begin
                done_cyc = c;
                break;
            end
        end
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        i_cfg_we = 1'b0; i_cfg_leaf = '0; i_cfg_base = '0; i_cfg_lines = '0;
        i_start = 1'b0; i_arready = 1'b1; i_buf_deq = '0;
        #12;
        n_cmp++;
        if ({o_arvalid, o_busy, o_done, o_rready} !== 4'b0 || o_buf_enq !== '0 ||
            o_araddr !== '0 || o_arid !== '0 || o_buf_data !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got arvalid=%b busy=%b done=%b rready=%b enq=%h addr=%h, expected all 0",
                     o_arvalid, o_busy, o_done, o_rready, o_buf_enq, o_araddr);
        end
        tick();
        i_rst_n = 1'b1;
        tick();
        n_cmp++;
        if (o_rready !== 1'b1 || o_busy !== 1'b0 || o_done !== 1'b0) begin
            n_bad++;
            $display("FAIL post_reset: got rready=%b busy=%b done=%b, expected 1 0 0", o_rready, o_busy, o_done);
        end
    endtask

    task automatic test_single_leaf();
        int le, dc, fh, lh, h0;
        do_reset();
        cfg(5, 32'h1000, 3);
        push_ar(32'h1000, 5); push_ar(32'h1040, 5); push_ar(32'h1080, 5);
        h0 = ar_hs;
        start_run();
        @(negedge i_clk);
        n_cmp++;
        if (o_arvalid !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_first_cycle: got arvalid=%b busy=%b, expected 0 1", o_arvalid, o_busy);
        end
        run_until_done(60, le, dc, fh, lh);
        n_cmp++;
        if (fh != 0 || lh != 2 || ar_hs - h0 != 3) begin
            n_bad++;
            $display("FAIL single_ar_timing: got first=%0d last=%0d count=%0d, expected 0 2 3", fh, lh, ar_hs - h0);
        end
        n_cmp++;
        if (dc < 0 || dc != le + 1 || exp_ar.size() != 0 || exp_enq.size() != 0) begin
            n_bad++;
            $display("FAIL single_done: got done_cyc=%0d last_enq=%0d, expected done one after enq with queues empty", dc, le);
        end
    endtask

    task automatic test_round_robin();
        int le, dc, fh, lh, h0;
        do_reset();
        for (int i = 0; i < 64; i++) cfg(i, 32'h0001_0000 + 32'(i) * 32'h1000, 2);
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < 64; i++) push_ar(32'h0001_0000 + 32'(i) * 32'h1000 + 32'(k) * 64, i);
        h0 = ar_hs;
        start_run();
        run_until_done(400, le, dc, fh, lh);
        n_cmp++;
        if (ar_hs - h0 != 128 || lh - fh != 127) begin
            n_bad++;
            $display("FAIL rr_count: got %0d requests over span %0d, expected 128 over 127", ar_hs - h0, lh - fh);
        end
        n_cmp++;
        if (dc < 0 || dc != le + 1 || exp_enq.size() != 0) begin
            n_bad++;
            $display("FAIL rr_done: got done_cyc=%0d last_enq=%0d, expected done one after enq", dc, le);
        end
    endtask

    task automatic test_credit_stall();
        int h0;
        do_reset();
        cfg(0, 32'h4000, 20);
        for (int k = 0; k < 8; k++) push_ar(32'h4000 + 32'(k) * 64, 0);
        h0 = ar_hs;
        start_run();
        repeat (30) @(negedge i_clk);
        n_cmp++;
        if (ar_hs - h0 != 8 || o_arvalid !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL credit_stall: got %0d requests arvalid=%b busy=%b, expected 8 0 1", ar_hs - h0, o_arvalid, o_busy);
        end
        push_ar(32'h4200, 0);
        tick();
        i_buf_deq = 64'd1;
        tick();
        i_buf_deq = '0;
        repeat (10) @(negedge i_clk);
        n_cmp++;
        if (ar_hs - h0 != 9 || o_arvalid !== 1'b0 || exp_ar.size() != 0) begin
            n_bad++;
            $display("FAIL credit_refill: got %0d requests arvalid=%b, expected 9 0", ar_hs - h0, o_arvalid);
        end
    endtask

    task automatic test_backpressure();
        int le, dc, fh, lh, h0;
        bit seen;
        do_reset();
        cfg(2, 32'h8000, 4);
        for (int k = 0; k < 4; k++) push_ar(32'h8000 + 32'(k) * 64, 2);
        i_arready = 1'b0;
        h0 = ar_hs;
        start_run();
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge i_clk);
            seen = o_arvalid;
        end
        n_cmp++;
        if (!seen) begin
            n_bad++;
            $display("FAIL bp_arvalid: got arvalid=0 within 10 cycles, expected 1");
        end
        for (int c = 0; c < 10; c++) begin
            @(negedge i_clk);
            n_cmp++;
            if (o_arvalid !== 1'b1 || o_araddr !== 32'h8000 || o_arid !== 6'd2 ||
                o_buf_enq !== '0 || ar_hs != h0) begin
                n_bad++;
                $display("FAIL bp_hold: got arvalid=%b addr=%h id=%0d enq=%h, expected 1 8000 2 0",
                         o_arvalid, o_araddr, o_arid, o_buf_enq);
            end
        end
        tick();
        i_arready = 1'b1;
        @(negedge i_clk);
        @(negedge i_clk);
        n_cmp++;
        if (o_arvalid !== 1'b1 || o_araddr !== 32'h8040) begin
            n_bad++;
            $display("FAIL bp_release: got arvalid=%b addr=%h, expected 1 8040", o_arvalid, o_araddr);
        end
        run_until_done(60, le, dc, fh, lh);
        n_cmp++;
        if (dc < 0 || ar_hs - h0 != 4 || exp_ar.size() != 0) begin
            n_bad++;
            $display("FAIL bp_done: got done_cyc=%0d count=%0d, expected done with 4 requests", dc, ar_hs - h0);
        end
    endtask

    task automatic test_simultaneous();
        int le, dc, fh, lh, h0;
        do_reset();
        cfg(0, 32'hC000, 12);
        cfg(1, 32'hD000, 3);
        for (int k = 0; k < 3; k++) begin
            push_ar(32'hC000 + 32'(k) * 64, 0);
            push_ar(32'hD000 + 32'(k) * 64, 1);
        end
        for (int k = 3; k < 12; k++) push_ar(32'hC000 + 32'(k) * 64, 0);
        h0 = ar_hs;
        i_buf_deq = 64'd1;
        start_run();
        run_until_done(100, le, dc, fh, lh);
        i_buf_deq = '0;
        n_cmp++;
        if (ar_hs - h0 != 15 || lh - fh != 14) begin
            n_bad++;
            $display("FAIL simul_stream: got %0d requests over span %0d, expected 15 over 14", ar_hs - h0, lh - fh);
        end
        n_cmp++;
        if (dc < 0 || dc != le + 1 || exp_enq.size() != 0) begin
            n_bad++;
            $display("FAIL simul_done: got done_cyc=%0d last_enq=%0d, expected done one after enq", dc, le);
        end
    endtask

    task automatic test_zero_and_reset();
        do_reset();
        start_run();
        @(negedge i_clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_c0: got done=%b busy=%b, expected 0 1", o_done, o_busy);
        end
        @(negedge i_clk);
        n_cmp++;
        if (o_done !== 1'b0 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL zero_c1: got done=%b busy=%b, expected 0 1", o_done, o_busy);
        end
        @(negedge i_clk);
        n_cmp++;
        if (o_done !== 1'b1 || o_busy !== 1'b0) begin
            n_bad++;
            $display("FAIL zero_c2: got done=%b busy=%b, expected 1 0", o_done, o_busy);
        end
        cfg(3, 32'h2000, 10);
        for (int k = 0; k < 10; k++) push_ar(32'h2000 + 32'(k) * 64, 3);
        start_run();
        repeat (6) @(negedge i_clk);
        n_cmp++;
        if (o_arvalid !== 1'b1 || o_busy !== 1'b1) begin
            n_bad++;
            $display("FAIL midrun_active: got arvalid=%b busy=%b, expected 1 1", o_arvalid, o_busy);
        end
        #2;
        i_rst_n = 1'b0;
        #1;
        n_cmp++;
        if ({o_arvalid, o_busy, o_done, o_rready} !== 4'b0 || o_buf_enq !== '0 ||
            o_araddr !== '0 || o_arid !== '0 || o_buf_data !== '0) begin
            n_bad++;
            $display("FAIL midrun_reset: got arvalid=%b busy=%b done=%b rready=%b addr=%h id=%0d, expected all 0",
                     o_arvalid, o_busy, o_done, o_rready, o_araddr, o_arid);
        end
        clear_sb();
        repeat (2) tick();
        clear_sb();
        i_rst_n = 1'b1;
        repeat (3) @(negedge i_clk);
        n_cmp++;
        if (o_busy !== 1'b0 || o_done !== 1'b0 || o_arvalid !== 1'b0) begin
            n_bad++;
            $display("FAIL after_reset_idle: got busy=%b done=%b arvalid=%b, expected 0 0 0", o_busy, o_done, o_arvalid);
        end
    endtask

    initial begin
        test_reset();
        test_single_leaf();
        test_round_robin();
        test_credit_stall();
        test_backpressure();
        test_simultaneous();
        test_zero_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
